pkg_word_streamer: RTL and testbench
====================================

Name: pkg_word_streamer

Overview:
Sequential source stage that streams the package constants pkg::a, pkg::b, pkg::c and pkg::d (4-bit; values 5, 6, 7, 8) to a downstream consumer over a valid/ready handshake. It sits directly upstream of the top-level consumer that displays these values. It replaces static continuous assignment with an ordered, flow-controlled stream and keeps a running sum for checking. The word table is taken by wildcard import of pkg; no local declaration may shadow a, b, c or d.

Parameters:
WIDTH, 4, data width; must equal the width of the pkg constants.
NUM_WORDS, 4, number of words streamed per burst; index 0..3 maps to a, b, c, d.
REPEAT, 0, 1 = restart the burst automatically after done; 0 = return to IDLE.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a burst; sampled only in IDLE
out_data  output  WIDTH  current word
out_idx  output  2  index of current word (0=a, 1=b, 2=c, 3=d)
out_valid  output  1  out_data/out_idx/out_last are valid
out_ready  input  1  consumer accepts the word when out_valid && out_ready
out_last  output  1  high with the final word of the burst
sum  output  WIDTH+2  running sum of accepted words in the current burst
busy  output  1  high in SEND and DONE
done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_valid=0, out_data=0, out_idx=0, out_last=0, sum=0, busy=0, done=0.
- FSM states IDLE, SEND, DONE.
- IDLE:
  - start=1 -> SEND; idx=0; sum=0.
  - out_valid rises on the next cycle, so start at edge N gives the first word valid after edge N+1 (one-cycle latency).
- SEND:
  - out_valid=1; out_data=table[idx]; out_last=(idx==NUM_WORDS-1).
  - While out_valid && !out_ready, out_data, out_idx and out_last hold stable.
  - On handshake: sum <= sum + out_data, zero-extended, with no overflow (max 4*15=60 < 64).
  - On handshake, if not last: idx <= idx+1. Back-to-back handshakes deliver one word per cycle.
  - On handshake of the last word: -> DONE; out_valid=0 next cycle.
- DONE:
  - done=1 for exactly one cycle; sum holds the final value (26 for default constants).
  - Then: REPEAT=0 -> IDLE with sum held; REPEAT=1 -> SEND with idx=0, sum cleared, first word valid next cycle.
- sum holds its value in IDLE until the next start.
- start while busy is ignored; no queuing.
- out_ready high while out_valid=0 has no effect.
- Reset asserted mid-burst: immediate return to the reset values; a partially streamed burst is abandoned, with no done pulse.
- out_idx wraps only by burst restart, never by incrementing past NUM_WORDS-1.

Test Plan:
- Reset, then start pulse with out_ready=1 constantly -> words 5,6,7,8 on four consecutive cycles with idx 0..3; out_last only with 8; done pulse the next cycle; sum=26; busy returns to 0.
- out_ready held low for 3 cycles while word 6 is presented -> out_data=6 and idx=1 stable all 3 cycles; sum remains 5 until accept; final sum=26.
- out_ready alternating 1/0 -> each word is accepted exactly once and in order; total cycles from first valid to done = 8.
- start re-pulsed during SEND at idx=2 -> ignored; stream continues 7,8; exactly one done pulse.
- rst_n dropped asynchronously after word 6 is accepted -> outputs zero immediately (same cycle, before the clock edge); a new start then gives 5,6,7,8 and sum=26.
- REPEAT=1 with out_ready=1 -> pattern 5,6,7,8 repeats; done pulses every 6 cycles (4 SEND + 1 DONE + 1 restart gap); sum resets at each restart.

Source files
------------

// File: rtl/pkg.sv
// pkg: shared 4-bit word constants consumed by the streamer
package pkg;
  parameter logic [3:0] a = 4'd5;
  parameter logic [3:0] b = 4'd6;
  parameter logic [3:0] c = 4'd7;
  parameter logic [3:0] d = 4'd8;
endpackage

// File: rtl/pkg_word_streamer.sv
// pkg_word_streamer: streams pkg::a..d over valid/ready, keeping a running sum of accepted words
module pkg_word_streamer
  import pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int NUM_WORDS = 4,
  parameter int REPEAT    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [WIDTH+1:0] sum,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  localparam logic [1:0] LAST_IDX = 2'(NUM_WORDS - 1);
  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [WIDTH+1:0] sum_q, sum_d;
  logic [WIDTH-1:0] word;
  logic             last;
  // word table lookup and last-word flag for the current index
  always_comb begin
    word = idx_q == 2'd0 ? WIDTH'(a) :
           idx_q == 2'd1 ? WIDTH'(b) :
           idx_q == 2'd2 ? WIDTH'(c) : WIDTH'(d);
    last = idx_q == LAST_IDX;
  end
  // burst sequencing: SEND spends one cycle raising valid, then advances one word per handshake
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SEND;
        idx_d   = 2'd0;
        sum_d   = '0;
      end
      SEND: if (!valid_q) valid_d = 1'b1;
        else if (out_ready) begin
          sum_d = sum_q + (WIDTH+2)'(word);
          if (last) begin
            state_d = DONE;
            valid_d = 1'b0;
          end else idx_d = idx_q + 2'd1;
        end
      DONE: if (REPEAT != 0) begin
        state_d = SEND;
        idx_d   = 2'd0;
        sum_d   = '0;
      end else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = valid_q ? word : '0;
  assign out_idx   = idx_q;
  assign out_last  = valid_q && last;
  assign sum       = sum_q;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
endmodule

// File: tb/tb_pkg_word_streamer.sv
// tb_pkg_word_streamer: randomized handshake bench against a word-queue scoreboard
module tb_pkg_word_streamer;
  logic       clk, rst_n, start, out_ready, rp_start;
  logic [3:0] out_data, r_data;
  logic [1:0] out_idx, r_idx;
  logic       out_valid, out_last, busy, done;
  logic       r_valid, r_last, r_busy, r_done;
  logic [5:0] sum, r_sum;
  int         checks = 0;
  int         failures = 0;
  int         tbl[4] = '{5, 6, 7, 8};

  pkg_word_streamer #(.WIDTH(4), .NUM_WORDS(4), .REPEAT(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .out_data(out_data), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .sum(sum),
    .busy(busy), .done(done)
  );

  pkg_word_streamer #(.WIDTH(4), .NUM_WORDS(4), .REPEAT(1)) rp (
    .clk(clk), .rst_n(rst_n), .start(rp_start), .out_data(r_data), .out_idx(r_idx),
    .out_valid(r_valid), .out_ready(1'b1), .out_last(r_last), .sum(r_sum),
    .busy(r_busy), .done(r_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_idx"}, out_idx, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // mode: 0 ready high, 1 alternating, 2 random, 3 stall on word b, 4 start poke, 5 reset after b
  task automatic run_burst(input int mode);
    int n = 0;
    int cyc = 0;
    int first = -1;
    int lows = 0;
    int msum = 0;
    bit exp_done = 0;
    bit finished = 0;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("lat_valid", out_valid, 0);
    chk("lat_busy", busy, 1);
    while (!finished && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      chk("done", done, exp_done);
      if (exp_done) begin
        if (mode == 0) chk("span", cyc - first + 1, 5);
        if (mode == 1) chk("span", cyc - first + 1, 8);
        chk("final_sum", sum, 26);
        chk("done_busy", busy, 1);
        finished = 1;
      end
      exp_done = 0;
      chk("valid", out_valid, n < 4);
      if (n < 4) begin
        if (first < 0) first = cyc;
        chk("data", out_data, tbl[n]);
        chk("idx", out_idx, n);
        chk("last", out_last, n == 3);
        chk("sum", sum, msum);
        if (mode == 5 && n == 2) begin
          #1 rst_n = 1'b0;
          #1 chk_zero("async_rst");
          @(negedge clk);
          chk_zero("held_rst");
          rst_n = 1'b1;
          finished = 1;
        end else begin
          case (mode)
            1:       out_ready = ((cyc - first) % 2) == 0;
            2:       out_ready = 1'($urandom_range(0, 1));
            3:       out_ready = !(n == 1 && lows < 3);
            default: out_ready = 1'b1;
          endcase
          if (mode == 3 && !out_ready) lows++;
          if (mode == 4 && n == 2) start = 1'b1;
          if (out_ready) begin
            msum += tbl[n];
            n++;
            exp_done = n == 4;
          end
        end
      end
    end
    if (!finished) chk("timeout", 0, 1);
    if (mode != 5) begin
      @(negedge clk);
      chk("post_busy", busy, 0);
      chk("post_done", done, 0);
      chk("post_valid", out_valid, 0);
      chk("post_sum", sum, 26);
    end
  endtask

  task automatic run_repeat();
    int n = 0;
    int msum = 0;
    int idle_left = 0;
    int last_done = -1;
    int dones = 0;
    bit exp_done = 0;
    rp_start = 1'b1;
    @(negedge clk);
    rp_start = 1'b0;
    chk("rp_lat", r_valid, 0);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      chk("rp_done", r_done, exp_done);
      if (exp_done) begin
        chk("rp_sum26", r_sum, 26);
        if (last_done >= 0) chk("rp_period", cyc - last_done, 6);
        last_done = cyc;
        dones++;
      end
      exp_done = 0;
      chk("rp_valid", r_valid, idle_left == 0);
      if (idle_left == 0) begin
        chk("rp_data", r_data, tbl[n]);
        chk("rp_idx", r_idx, n);
        chk("rp_last", r_last, n == 3);
        chk("rp_sum", r_sum, msum);
        msum += tbl[n];
        n++;
        if (n == 4) begin
          n = 0;
          msum = 0;
          idle_left = 2;
          exp_done = 1;
        end
      end else idle_left--;
    end
    chk("rp_dones", dones, 5);
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    rp_start = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    chk("rp_reset_valid", r_valid, 0);
    chk("rp_reset_busy", r_busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_burst(0);
    run_burst(3);
    run_burst(1);
    for (int r = 0; r < 4; r++) run_burst(2);
    run_burst(4);
    run_burst(5);
    run_burst(0);
    run_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
